ram_dp_clr: RTL and testbench
=============================

# ram_dp_clr

Parametrised dual-port data RAM for the Hack platform, and the successor to the single-port `RAM` block. Port A is the CPU read/write port, with the same `in`/`address`/`load`/`out` semantics plus a registered read. Port B is a read-only port for the screen scanner. On every reset, a hardware clear sequencer zeroes the whole array. Out-of-range accesses are trapped and flagged, so a 16-bit Hack address can safely drive a smaller memory.

## Interface
- `DEPTH`, 32767: number of words; legal addresses are 0..DEPTH-1.
- `WIDTH`, 16: word width in bits.
- `ADDR_W`, 16: address bus width; DEPTH ≤ 2^ADDR_W.
- `CLEAR_ON_RESET`, 1: 1 = sweep zeros through the array after reset; 0 = contents untouched, ready immediately.
- `READ_FIRST`, 0: port A read-during-write behaviour. 0 = write-first (`out` shows the new data); 1 = read-first (`out` shows the old data).
- `clk`  in  1  system clock; all state changes on posedge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in`  in  WIDTH  port A write data.
- `address`  in  ADDR_W  port A address.
- `load`  in  1  port A write enable.
- `out`  out  WIDTH  port A registered read data.
- `vaddr`  in  ADDR_W  port B read address.
- `vout`  out  WIDTH  port B registered read data.
- `busy`  out  1  clear sweep in progress; port A is blocked while high.
- `oob`  out  1  sticky flag: a port A access used `address` ≥ DEPTH.

## Operation
- FSM states:
  - CLEAR: sweep in progress; entered from reset when CLEAR_ON_RESET=1.
  - READY: normal operation; entered from reset when CLEAR_ON_RESET=0, or from CLEAR as described below.
  - While `rst_n`=0 at a posedge, the FSM goes to the reset-entry state, the sweep pointer becomes 0, and all outputs take their reset values.
- CLEAR:
  - Each cycle, write 0 to `mem[ptr]` and increment `ptr`.
  - When the write to `ptr`=DEPTH-1 completes, go to READY.
  - Port A `load` is ignored and `out` holds 0; the `oob` check is disabled.
  - Port B keeps reading and returns whatever the array currently holds (a mix of zeros and not-yet-cleared data).
- READY, port A:
  - If `address` < DEPTH and `load`=1, write `mem[address]` ← `in`.
  - The `out` register loads `mem[address]`, following the READ_FIRST rule when a write hits the same address in the same cycle.
  - If `address` ≥ DEPTH: no write, `out` ← 0, `oob` ← 1. This applies to both reads and writes.
- Port B, all states:
  - `vout` ← `mem[vaddr]` if `vaddr` < DEPTH, else 0.
  - Port B never sets `oob`.
  - If port A writes the address port B is reading in the same cycle, `vout` returns the old data, regardless of READ_FIRST.
- `oob` clears only on reset.
- `ptr` is internal and $clog2(DEPTH) bits wide. Address comparisons are unsigned at ADDR_W bits.

## Timing
- Reset values: `out`=0, `vout`=0, `oob`=0, `busy`=CLEAR_ON_RESET.
- Clear duration: exactly DEPTH cycles.
  - Posedge k after reset release (k=1..DEPTH) writes address k-1.
  - `busy` falls at posedge DEPTH; port A accepts writes from the following posedge.
- Port A and port B read latency: 1 cycle. Data presented before posedge N is valid on `out`/`vout` after posedge N.
- Write latency: a write at posedge N is visible via a read address applied for posedge N+1.
- Reset asserted mid-sweep: the sweep restarts at address 0 with full DEPTH duration after release.
- Reset in READY with CLEAR_ON_RESET=0: array contents are preserved.

## Test plan
- Clear sweep (DEPTH=16, CLEAR_ON_RESET=1):
  - Preload the array, pulse `rst_n` low for 2 cycles.
  - `busy` is high for exactly 16 posedges; afterwards, reads of 0..15 on both ports return 0.
- Write/read latency (READY, DEPTH=32767):
  - Write 0xBEEF to address 100, then read address 100 with load=0 → `out`=0xBEEF one cycle later.
  - Port B `vaddr`=100 → `vout`=0xBEEF.
- Read-during-write on port A:
  - `mem[5]`=0x1111; write 0x2222 to address 5 with `address` held.
  - READ_FIRST=0 → `out`=0x2222 that cycle; READ_FIRST=1 → `out`=0x1111, then 0x2222 next cycle.
- Out of range (DEPTH=32767):
  - `address`=32767, `load`=1, `in`=0xFFFF → `out`=0, `oob`=1, and `mem[0]` is unchanged.
  - `oob` stays 1 until reset; `vaddr`=40000 → `vout`=0 and does not affect `oob`.
- Blocked writes and mid-sweep reset (DEPTH=16):
  - During CLEAR, `load`=1, `address`=3, `in`=0x00AA → ignored; `mem[3]`=0 after the sweep.
  - Assert `rst_n` at sweep cycle 8 → `busy` stays high for a full 16 cycles after release.
- No-clear mode (CLEAR_ON_RESET=0):
  - Write 0x1234 to address 7, pulse reset → `busy` never rises, and `mem[7]` still reads 0x1234.

Source files
------------

// File: rtl/ram_dp_clr.sv
`default_nettype none
// ============================================================================
// Module      : ram_dp_clr
// Description : Dual-port Hack data RAM. Port A is CPU read/write, port B is a
//               read-only scanner port. Optional zero-sweep after reset and a
//               sticky out-of-range flag for port A.
// Revision    : 1.0
// ============================================================================
module ram_dp_clr #(
    parameter int DEPTH          = 32767,
    parameter int WIDTH          = 16,
    parameter int ADDR_W         = 16,
    parameter int CLEAR_ON_RESET = 1,
    parameter int READ_FIRST     = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  in,
    input  logic [ADDR_W-1:0] address,
    input  logic              load,
    output logic [WIDTH-1:0]  out,
    input  logic [ADDR_W-1:0] vaddr,
    output logic [WIDTH-1:0]  vout,
    output logic              busy,
    output logic              oob
);

    localparam int                  c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]     c_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [c_PTR_W-1:0]  c_LAST  = c_PTR_W'(DEPTH - 1);
    localparam logic [c_PTR_W-1:0]  c_ONE   = c_PTR_W'(1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam state_t c_ENTRY = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_PTR_W-1:0]  r_ptr;
    logic [c_PTR_W-1:0]  w_ptr_nxt;
    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [WIDTH-1:0]    r_out;
    logic [WIDTH-1:0]    r_vout;
    logic                r_oob;

    logic                w_a_ok;
    logic                w_b_ok;
    logic [c_PTR_W-1:0]  w_a_idx;
    logic [c_PTR_W-1:0]  w_b_idx;
    logic                w_we;
    logic [c_PTR_W-1:0]  w_widx;
    logic [WIDTH-1:0]    w_wdata;

    // Compare one bit wider so DEPTH == 2**ADDR_W is still representable.
    assign w_a_ok  = {1'b0, address} < c_DEPTH;
    assign w_b_ok  = {1'b0, vaddr} < c_DEPTH;
    assign w_a_idx = address[c_PTR_W-1:0];
    assign w_b_idx = vaddr[c_PTR_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ENTRY;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_we        = 1'b0;
        w_widx      = w_a_idx;
        w_wdata     = in;
        case (r_state)
            ST_CLEAR: begin
                w_we      = 1'b1;
                w_widx    = r_ptr;
                w_wdata   = '0;
                w_ptr_nxt = r_ptr + c_ONE;
                if (r_ptr == c_LAST) begin
                    w_state_nxt = ST_READY;
                    w_ptr_nxt   = '0;
                end
            end
            ST_READY: begin
                w_we = load && w_a_ok;
            end
            default: begin
                w_state_nxt = c_ENTRY;
            end
        endcase
    end

    // Single shared write port: the sweep and port A never write together.
    always_ff @(posedge clk) begin
        if (rst_n && w_we) begin
            r_mem[w_widx] <= w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out <= '0;
            r_oob <= 1'b0;
        end else if (r_state == ST_READY) begin
            if (w_a_ok) begin
                r_out <= (load && (READ_FIRST == 0)) ? in : r_mem[w_a_idx];
            end else begin
                r_out <= '0;
                r_oob <= 1'b1;
            end
        end else begin
            r_out <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vout <= '0;
        end else begin
            r_vout <= w_b_ok ? r_mem[w_b_idx] : '0;
        end
    end

    assign out  = r_out;
    assign vout = r_vout;
    assign oob  = r_oob;
    assign busy = (r_state == ST_CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_ram_dp_clr.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_dp_clr
// Description : Scoreboard bench for ram_dp_clr across three configurations.
// Revision    : 1.0
// ============================================================================
module tb_ram_dp_clr;

    localparam int c_OUT  = 0;
    localparam int c_VOUT = 1;
    localparam int c_BUSY = 2;
    localparam int c_OOB  = 3;

    logic        clk = 1'b0;
    logic        rst_n_s [3];
    logic [15:0] in_s    [3];
    logic [15:0] addr_s  [3];
    logic        load_s  [3];
    logic [15:0] out_s   [3];
    logic [15:0] vaddr_s [3];
    logic [15:0] vout_s  [3];
    logic        busy_s  [3];
    logic        oob_s   [3];

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        string       tag;
        int          d;
        int          sig;
        logic [15:0] exp;
    } exp_t;

    exp_t sb [$];

    always #5 clk = ~clk;

    // 0: small clearing RAM, 1: full-size write-first, 2: full-size read-first
    ram_dp_clr #(.DEPTH(16), .WIDTH(16), .ADDR_W(16), .CLEAR_ON_RESET(1), .READ_FIRST(0)) u_a (
        .clk(clk), .rst_n(rst_n_s[0]), .in(in_s[0]), .address(addr_s[0]), .load(load_s[0]),
        .out(out_s[0]), .vaddr(vaddr_s[0]), .vout(vout_s[0]), .busy(busy_s[0]), .oob(oob_s[0]));

    ram_dp_clr #(.DEPTH(32767), .WIDTH(16), .ADDR_W(16), .CLEAR_ON_RESET(0), .READ_FIRST(0)) u_b (
        .clk(clk), .rst_n(rst_n_s[1]), .in(in_s[1]), .address(addr_s[1]), .load(load_s[1]),
        .out(out_s[1]), .vaddr(vaddr_s[1]), .vout(vout_s[1]), .busy(busy_s[1]), .oob(oob_s[1]));

    ram_dp_clr #(.DEPTH(32767), .WIDTH(16), .ADDR_W(16), .CLEAR_ON_RESET(0), .READ_FIRST(1)) u_c (
        .clk(clk), .rst_n(rst_n_s[2]), .in(in_s[2]), .address(addr_s[2]), .load(load_s[2]),
        .out(out_s[2]), .vaddr(vaddr_s[2]), .vout(vout_s[2]), .busy(busy_s[2]), .oob(oob_s[2]));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] observe(input int d, input int sig);
        case (sig)
            c_OUT:   return out_s[d];
            c_VOUT:  return vout_s[d];
            c_BUSY:  return {15'b0, busy_s[d]};
            default: return {15'b0, oob_s[d]};
        endcase
    endfunction

    task automatic push(input string tag, input int d, input int sig, input logic [15:0] e);
        exp_t x;
        x.tag = tag;
        x.d   = d;
        x.sig = sig;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, observe(e.d, e.sig), e.exp);
        end
    endtask

    task automatic set(input int d, input logic r, input logic ld, input logic [15:0] a,
                       input logic [15:0] i, input logic [15:0] va);
        rst_n_s[d] = r;
        load_s[d]  = ld;
        addr_s[d]  = a;
        in_s[d]    = i;
        vaddr_s[d] = va;
    endtask

    function automatic logic [15:0] pre(input int i);
        return 16'(i * 16'h0101 + 1);
    endfunction

    initial begin
        for (int d = 0; d < 3; d++) set(d, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
        tick();
        for (int d = 0; d < 3; d++) begin
            push("rst_out", d, c_OUT, 16'h0);
            push("rst_vout", d, c_VOUT, 16'h0);
            push("rst_oob", d, c_OOB, 16'h0);
            push("rst_busy", d, c_BUSY, (d == 0) ? 16'h1 : 16'h0);
        end
        tick();
        for (int d = 0; d < 3; d++) rst_n_s[d] = 1'b1;

        // DUT 0: first sweep while port A tries to write address 3
        set(0, 1'b1, 1'b1, 16'd3, 16'h00AA, 16'd0);
        for (int k = 1; k <= 16; k++) begin
            push("sweep1_busy", 0, c_BUSY, (k < 16) ? 16'h1 : 16'h0);
            push("sweep1_out", 0, c_OUT, 16'h0);
            tick();
        end
        set(0, 1'b1, 1'b0, 16'd3, 16'h0, 16'd3);
        push("blocked_out", 0, c_OUT, 16'h0);
        push("blocked_vout", 0, c_VOUT, 16'h0);
        tick();

        for (int i = 0; i < 16; i++) begin
            set(0, 1'b1, 1'b1, 16'(i), pre(i), 16'd0);
            push("preload_out", 0, c_OUT, pre(i));
            tick();
        end
        set(0, 1'b1, 1'b0, 16'd9, 16'h0, 16'd9);
        push("preload_rd", 0, c_OUT, pre(9));
        push("preload_vrd", 0, c_VOUT, pre(9));
        tick();

        set(0, 1'b0, 1'b0, 16'd0, 16'h0, 16'd15);
        for (int k = 0; k < 2; k++) begin
            push("rst2_busy", 0, c_BUSY, 16'h1);
            push("rst2_out", 0, c_OUT, 16'h0);
            push("rst2_vout", 0, c_VOUT, 16'h0);
            tick();
        end
        rst_n_s[0] = 1'b1;
        // Entry 15 is cleared on the last sweep edge, so port B sees old data throughout.
        for (int k = 1; k <= 16; k++) begin
            push("sweep2_busy", 0, c_BUSY, (k < 16) ? 16'h1 : 16'h0);
            push("sweep2_vout", 0, c_VOUT, pre(15));
            tick();
        end
        for (int i = 0; i < 16; i++) begin
            set(0, 1'b1, 1'b0, 16'(i), 16'h0, 16'(i));
            push("clr_out", 0, c_OUT, 16'h0);
            push("clr_vout", 0, c_VOUT, 16'h0);
            tick();
        end

        rst_n_s[0] = 1'b0;
        push("mid_rst_busy", 0, c_BUSY, 16'h1);
        tick();
        rst_n_s[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            push("mid_pre_busy", 0, c_BUSY, 16'h1);
            tick();
        end
        rst_n_s[0] = 1'b0;
        push("mid_hit_busy", 0, c_BUSY, 16'h1);
        tick();
        rst_n_s[0] = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            push("mid_post_busy", 0, c_BUSY, (k < 16) ? 16'h1 : 16'h0);
            tick();
        end

        // DUT 1: write-first, full depth, no clear
        set(1, 1'b1, 1'b1, 16'd100, 16'hBEEF, 16'd0);
        push("wr100_out", 1, c_OUT, 16'hBEEF);
        tick();
        set(1, 1'b1, 1'b0, 16'd100, 16'h0, 16'd100);
        push("rd100_out", 1, c_OUT, 16'hBEEF);
        push("rd100_vout", 1, c_VOUT, 16'hBEEF);
        tick();
        set(1, 1'b1, 1'b1, 16'd5, 16'h1111, 16'd0);
        push("wf_first", 1, c_OUT, 16'h1111);
        tick();
        set(1, 1'b1, 1'b1, 16'd5, 16'h2222, 16'd0);
        push("wf_rdw", 1, c_OUT, 16'h2222);
        tick();
        set(1, 1'b1, 1'b0, 16'd5, 16'h0, 16'd0);
        push("wf_after", 1, c_OUT, 16'h2222);
        tick();
        set(1, 1'b1, 1'b1, 16'd0, 16'h0055, 16'd0);
        push("oob_pre", 1, c_OOB, 16'h0);
        tick();
        set(1, 1'b1, 1'b1, 16'd32767, 16'hFFFF, 16'd0);
        push("oob_out", 1, c_OUT, 16'h0);
        push("oob_set", 1, c_OOB, 16'h1);
        tick();
        set(1, 1'b1, 1'b0, 16'd0, 16'h0, 16'd40000);
        push("oob_mem0", 1, c_OUT, 16'h0055);
        push("oob_vout", 1, c_VOUT, 16'h0);
        push("oob_sticky", 1, c_OOB, 16'h1);
        tick();
        for (int k = 0; k < 3; k++) begin
            push("oob_hold", 1, c_OOB, 16'h1);
            tick();
        end
        set(1, 1'b1, 1'b1, 16'd7, 16'h1234, 16'd0);
        push("nc_wr", 1, c_OUT, 16'h1234);
        tick();
        set(1, 1'b0, 1'b0, 16'd7, 16'h0, 16'd0);
        push("nc_rst_busy", 1, c_BUSY, 16'h0);
        push("nc_rst_oob", 1, c_OOB, 16'h0);
        push("nc_rst_out", 1, c_OUT, 16'h0);
        tick();
        push("nc_rst_busy2", 1, c_BUSY, 16'h0);
        tick();
        set(1, 1'b1, 1'b0, 16'd7, 16'h0, 16'd7);
        push("nc_keep_out", 1, c_OUT, 16'h1234);
        push("nc_keep_vout", 1, c_VOUT, 16'h1234);
        push("nc_busy", 1, c_BUSY, 16'h0);
        tick();

        // DUT 2: read-first port A; port B always sees old data on a collision
        set(2, 1'b1, 1'b1, 16'd5, 16'h1111, 16'd40000);
        push("rf_vout_oor", 2, c_VOUT, 16'h0);
        tick();
        set(2, 1'b1, 1'b1, 16'd5, 16'h2222, 16'd5);
        push("rf_rdw", 2, c_OUT, 16'h1111);
        push("rf_vout_old", 2, c_VOUT, 16'h1111);
        push("rf_no_oob", 2, c_OOB, 16'h0);
        tick();
        set(2, 1'b1, 1'b0, 16'd5, 16'h0, 16'd5);
        push("rf_after", 2, c_OUT, 16'h2222);
        push("rf_vout_new", 2, c_VOUT, 16'h2222);
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
